// File: rtl/cdma_rd_resp.sv
// CDMA read responder: accepts one read command at a time, issues aligned word reads, and returns a buffered beat stream.
// Optional feature macro CDMA_RD_RESP_BE_EN: when defined, first/last beats carry partial byte enables; otherwise every beat uses 4'hF.
module cdma_rd_resp #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        dma_r_req,
   output logic        dma_r_ack,
   input  logic [31:0] dma_r_addr,
   input  logic [15:0] dma_r_len,
   output logic        dma_dvld,
   output logic        dma_rd_last,
   output logic [31:0] dma_rdata,
   output logic [3:0]  dma_rbe,
   input  logic        dma_dack,
   output logic        mem_rd_en,
   output logic [31:0] mem_rd_addr,
   input  logic [31:0] mem_rd_data
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 37;

   typedef enum logic [1:0] {IDLE, ACK, ISSUE, DRAIN} state_t;
   state_t state_reg, state_next;

   logic [31:0]   addr_reg;
   logic [16:0]   words_left_reg;
   logic          first_reg;
   logic [1:0]    s_reg;
   logic [1:0]    e_reg;
   logic [16:0]   word_cnt;
   logic          is_last;
   logic [3:0]    issue_be;
   logic [CW:0]   occupancy;
   logic          credit_ok;

   logic          infl_reg;
   logic          infl_last_reg;
   logic [3:0]    infl_be_reg;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] fifo_cnt_reg;
   logic [CW-1:0] fifo_cnt_next;
   logic          out_load;
   logic          arr_pop;
   logic          arr_push;
   logic          out_vld_next;
   logic [EW-1:0] in_entry;

   assign word_cnt    = (({15'd0, dma_r_addr[1:0]} + {1'b0, dma_r_len}) >> 2) + 17'd1;
   assign is_last     = (words_left_reg == 17'd1);
   assign mem_rd_addr = addr_reg;

   // Output register counts toward occupancy so issued-but-unaccepted words never exceed FIFO_DEPTH.
   assign occupancy = {1'b0, fifo_cnt_reg} + (CW+1)'(dma_dvld) + (CW+1)'(infl_reg);
   assign credit_ok = (occupancy < (CW+1)'(FIFO_DEPTH));

`ifdef CDMA_RD_RESP_BE_EN
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_be
         assign issue_be[gi] = (!first_reg || (2'(gi) >= s_reg)) &&
                               (!is_last   || (2'(gi) <= e_reg));
      end
   endgenerate
`else
   logic be_unused;
   assign be_unused = ^{first_reg, s_reg, e_reg};
   assign issue_be  = 4'hF;
`endif

   assign in_entry      = {mem_rd_data, infl_be_reg, infl_last_reg};
   assign out_load      = !dma_dvld || dma_dack;
   assign arr_pop       = out_load && (fifo_cnt_reg != '0);
   assign arr_push      = infl_reg && !(out_load && (fifo_cnt_reg == '0));
   assign fifo_cnt_next = fifo_cnt_reg + CW'(arr_push) - CW'(arr_pop);
   assign out_vld_next  = out_load ? ((fifo_cnt_reg != '0) || infl_reg) : 1'b1;

   always_comb begin
      state_next = state_reg;
      dma_r_ack  = 1'b0;
      mem_rd_en  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (dma_r_req) state_next = ACK;
         end
         ACK: begin
            dma_r_ack  = 1'b1;
            state_next = ISSUE;
         end
         ISSUE: begin
            mem_rd_en = credit_ok;
            if (credit_ok && is_last) state_next = DRAIN;
         end
         DRAIN: begin
            // Leave as the final beat is taken so the next command can start one cycle later.
            if ((fifo_cnt_next == '0) && !out_vld_next) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         words_left_reg <= '0;
         first_reg      <= 1'b0;
         s_reg          <= '0;
         e_reg          <= '0;
         infl_reg       <= 1'b0;
         infl_be_reg    <= '0;
         infl_last_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         infl_reg      <= mem_rd_en;
         infl_be_reg   <= issue_be;
         infl_last_reg <= is_last;
         if ((state_reg == IDLE) && dma_r_req) begin
            addr_reg       <= {dma_r_addr[31:2], 2'b00};
            words_left_reg <= word_cnt;
            first_reg      <= 1'b1;
            s_reg          <= dma_r_addr[1:0];
            e_reg          <= dma_r_addr[1:0] + dma_r_len[1:0];
         end else if (mem_rd_en) begin
            addr_reg       <= addr_reg + 32'd4;
            words_left_reg <= words_left_reg - 17'd1;
            first_reg      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
         dma_dvld     <= 1'b0;
         dma_rdata    <= '0;
         dma_rbe      <= '0;
         dma_rd_last  <= 1'b0;
      end else begin
         fifo_cnt_reg <= fifo_cnt_next;
         dma_dvld     <= out_vld_next;
         if (arr_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         // Returning data bypasses the array when it is empty and the output slot is free.
         if (arr_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            {dma_rdata, dma_rbe, dma_rd_last} <= fifo_mem[rd_ptr_reg];
         end else if (out_load && infl_reg) begin
            {dma_rdata, dma_rbe, dma_rd_last} <= in_entry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arr_push) fifo_mem[wr_ptr_reg] <= in_entry;
   end

endmodule

// File: tb/tb_cdma_rd_resp.sv
// Randomized bench for cdma_rd_resp: byte-level reference model, scoreboard on every accepted beat,
// cycle-exact latency checks when dack is held high.
module tb_cdma_rd_resp;
   localparam int DEPTH = 4;
`ifdef CDMA_RD_RESP_BE_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        dma_r_req;
   logic        dma_r_ack;
   logic [31:0] dma_r_addr;
   logic [15:0] dma_r_len;
   logic        dma_dvld;
   logic        dma_rd_last;
   logic [31:0] dma_rdata;
   logic [3:0]  dma_rbe;
   logic        dma_dack;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data;

   always #5 clk = ~clk;

   cdma_rd_resp #(.FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .dma_r_req   (dma_r_req),
      .dma_r_ack   (dma_r_ack),
      .dma_r_addr  (dma_r_addr),
      .dma_r_len   (dma_r_len),
      .dma_dvld    (dma_dvld),
      .dma_rd_last (dma_rd_last),
      .dma_rdata   (dma_rdata),
      .dma_rbe     (dma_rbe),
      .dma_dack    (dma_dack),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data)
   );

   typedef struct packed {
      logic [31:0] wa;
      logic [3:0]  be;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] exp_addr_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int dack_mode = 0;
   int dack_phase = 0;
   int ack_cnt = 0;
   int cmd_cnt = 0;
   int beats_seen = 0;
   int first_beat_cyc = -1;
   int last_beat_cyc = -1;
   int issued = 0;
   int accepted = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_rdata;
   logic [3:0]  prev_rbe;
   logic        prev_last;
   beat_t       mon_b;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_evt(input string name, input string what);
      total++;
      bad++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic finish_now();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference: walk every byte of the command, grouping bytes by their aligned word.
   task automatic build_cmd(input logic [31:0] a, input logic [15:0] l, output int w);
      logic [31:0] ba;
      logic [31:0] cur;
      logic [3:0]  be;
      bit          have;
      beat_t       b;
      have = 0;
      be   = '0;
      cur  = '0;
      w    = 0;
      for (int i = 0; i <= int'(l); i++) begin
         ba = a + 32'(i);
         if (have && ({ba[31:2], 2'b00} != cur)) begin
            b.wa = cur; b.be = be; b.last = 1'b0;
            exp_q.push_back(b);
            exp_addr_q.push_back(cur);
            w++;
            be = '0;
         end
         cur = {ba[31:2], 2'b00};
         have = 1;
         be[ba[1:0]] = 1'b1;
      end
      b.wa = cur; b.be = be; b.last = 1'b1;
      exp_q.push_back(b);
      exp_addr_q.push_back(cur);
      w++;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : $urandom();

   initial begin
      dma_dack = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (dack_mode)
            0:       dma_dack = 1'b1;
            1:       dma_dack = ((dack_phase % 4) == 0) || ((dack_phase % 4) == 3);
            default: dma_dack = 1'($urandom_range(0, 1));
         endcase
         dack_phase++;
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         prev_hold = 1'b0;
      end else begin
         if (dma_r_ack) ack_cnt++;
         if (mem_rd_en) begin
            issued++;
            if (exp_addr_q.size() == 0) fail_evt("mem_extra_issue", $sformatf("addr %h issued, none required", mem_rd_addr));
            else chk("mem_rd_addr", mem_rd_addr, exp_addr_q.pop_front());
         end
         if (prev_hold)
            chk("hold_stable", {dma_dvld, dma_rdata, dma_rbe, dma_rd_last},
                {1'b1, prev_rdata, prev_rbe, prev_last});
         if (dma_dvld && dma_dack) begin
            accepted++;
            if (exp_q.size() == 0) begin
               fail_evt("beat_extra", $sformatf("data %h delivered, none required", dma_rdata));
            end else begin
               mon_b = exp_q.pop_front();
               chk("beat_data", dma_rdata, mem_word(mon_b.wa));
               chk("beat_rbe", dma_rbe, BE_EN ? mon_b.be : 4'hF);
               chk("beat_last", dma_rd_last, mon_b.last);
               if (beats_seen == 0) first_beat_cyc = cyc;
               beats_seen++;
               if (mon_b.last) last_beat_cyc = cyc;
            end
         end
         total++;
         if (issued - accepted > DEPTH) begin
            bad++;
            $display("FAIL outstanding: got %0d words ahead, required at most %0d", issued - accepted, DEPTH);
         end
         prev_hold  = dma_dvld && !dma_dack;
         prev_rdata = dma_rdata;
         prev_rbe   = dma_rbe;
         prev_last  = dma_rd_last;
      end
   end

   task automatic run_cmd(input logic [31:0] a, input logic [15:0] l, input int mode,
                          input bit release_rst, output int w);
      int c0;
      int n;
      dack_mode = mode;
      build_cmd(a, l, w);
      beats_seen = 0;
      first_beat_cyc = -1;
      last_beat_cyc = -1;
      cmd_cnt++;
      dma_r_addr = a;
      dma_r_len  = l;
      dma_r_req  = 1'b1;
      if (release_rst) rstn = 1'b1;
      c0 = cyc;
      n = 0;
      do begin
         step();
         n++;
      end while (!dma_r_ack && n < 50);
      if (!dma_r_ack) begin
         fail_evt("ack_timeout", "no ack within 50 cycles");
         finish_now();
      end
      dma_r_req = 1'b0;
      if (mode == 0) chk("ack_cycle", cyc - c0, 1);
      n = 0;
      while (exp_q.size() != 0 && n < 60000) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_evt("drain_timeout", $sformatf("%0d beats never delivered", exp_q.size()));
         finish_now();
      end
      chk("ack_count", ack_cnt, cmd_cnt);
      chk("issue_all", exp_addr_q.size(), 0);
      if (mode == 0) begin
         chk("first_beat_cycle", first_beat_cyc - c0, 4);
         chk("last_beat_cycle", last_beat_cyc - c0, 3 + w);
      end
      $display("cmd addr=%h len=%0d words=%0d dack_mode=%0d", a, l, w, mode);
   endtask

   initial begin
      int w;
      logic [31:0] ra;
      logic [15:0] rl;
      rstn       = 1'b0;
      dma_r_req  = 1'b0;
      dma_r_addr = '0;
      dma_r_len  = '0;
      repeat (3) step();
      chk("rst_ack", dma_r_ack, 0);
      chk("rst_dvld", dma_dvld, 0);
      chk("rst_last", dma_rd_last, 0);
      chk("rst_rdata", dma_rdata, 0);
      chk("rst_rbe", dma_rbe, 0);
      chk("rst_mem_en", mem_rd_en, 0);
      chk("rst_mem_addr", mem_rd_addr, 0);
      rstn = 1'b1;
      step();

      // Pin the reference model against hand-computed word lists.
      build_cmd(32'h100, 16'd23, w);
      chk("model_w_aligned", w, 6);
      chk("model_wa_first", exp_q[0].wa, 32'h100);
      chk("model_wa_last", exp_q[5].wa, 32'h114);
      chk("model_last_flag", {exp_q[4].last, exp_q[5].last}, 2'b01);
      chk("model_be_aligned", {exp_q[0].be, exp_q[5].be}, 8'hFF);
      exp_q.delete(); exp_addr_q.delete();
      build_cmd(32'h203, 16'd5, w);
      chk("model_w_unaligned", w, 3);
      chk("model_be_unaligned", {exp_q[0].be, exp_q[1].be, exp_q[2].be}, 12'h8F1);
      chk("model_wa_unaligned", exp_q[2].wa, 32'h208);
      exp_q.delete(); exp_addr_q.delete();
      build_cmd(32'h301, 16'd1, w);
      chk("model_single", {w[3:0], exp_q[0].be, 3'b000, exp_q[0].last}, 12'h161);
      exp_q.delete(); exp_addr_q.delete();
      build_cmd(32'hFFFF_FFFC, 16'd7, w);
      chk("model_wrap", {exp_q[0].wa, exp_q[1].wa}, 64'hFFFF_FFFC_0000_0000);
      exp_q.delete(); exp_addr_q.delete();
      build_cmd(32'h3, 16'hFFFF, w);
      chk("model_w_max", w, 16385);
      exp_q.delete(); exp_addr_q.delete();

      run_cmd(32'h100, 16'd23, 0, 0, w);
      run_cmd(32'h203, 16'd5, 0, 0, w);
      run_cmd(32'h301, 16'd1, 0, 0, w);
      run_cmd(32'hFFFF_FFFC, 16'd7, 0, 0, w);
      run_cmd(32'h0, 16'd63, 1, 0, w);
      run_cmd(32'h1234_5677, 16'd90, 2, 0, w);
      run_cmd(32'h8000_0003, 16'hFFFF, 0, 0, w);
      for (int k = 0; k < 12; k++) begin
         ra = $urandom();
         rl = 16'($urandom_range(0, ((k % 4) == 3) ? 300 : 40));
         run_cmd(ra, rl, int'($urandom_range(0, 2)), 0, w);
      end

      // Reset during beat 3 of a 6-beat command.
      dack_mode = 0;
      build_cmd(32'h100, 16'd23, w);
      beats_seen = 0;
      dma_r_addr = 32'h100;
      dma_r_len  = 16'd23;
      dma_r_req  = 1'b1;
      step();
      chk("rst_test_ack", dma_r_ack, 1);
      dma_r_req = 1'b0;
      repeat (5) step();
      chk("pre_reset_beats", {31'd0, dma_dvld, 32'(beats_seen)}, {31'd0, 1'b1, 32'd2});
      rstn = 1'b0;
      #1;
      chk("midrst_outputs", {dma_r_ack, dma_dvld, dma_rd_last, dma_rbe, mem_rd_en},
          {1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
      chk("midrst_rdata", dma_rdata, 0);
      chk("midrst_mem_addr", mem_rd_addr, 0);
      exp_q.delete();
      exp_addr_q.delete();
      issued = 0;
      accepted = 0;
      ack_cnt = 0;
      cmd_cnt = 0;
      dma_r_req = 1'b1;
      repeat (2) begin
         step();
         chk("inrst_quiet", {dma_r_ack, dma_dvld, mem_rd_en}, 3'b000);
      end
      run_cmd(32'h40, 16'd11, 0, 1, w);
      run_cmd(32'h502, 16'd30, 1, 0, w);

      repeat (3) step();
      finish_now();
   end

   initial begin
      #5_000_000;
      fail_evt("watchdog", "simulation time limit reached");
      finish_now();
   end

endmodule

// File: doc/cdma_rd_resp.md
# cdma_rd_resp

Memory-side responder for the CDMA read-request interface. It accepts one read command at a time (byte address, byte length counted from 0) and issues aligned 32-bit word reads to a fixed-latency memory port. It returns the words as a beat stream with per-beat byte enables and a last flag, and honours the requester's data acknowledge. It sits between the DMA read initiators (command fetch, data read channels) and the local SRAM/bus bridge.

## Interface
- FIFO_DEPTH, 4: output beat buffer depth; power of 2, ≥4 (4 sustains 1 beat/cycle).
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous assert, active low.
- dma_r_req  input  1  read command request, level; held until acked.
- dma_r_ack  output  1  one-cycle pulse; command captured.
- dma_r_addr  input  32  start byte address; any alignment.
- dma_r_len  input  16  byte length minus 1.
- dma_dvld  output  1  beat valid.
- dma_rd_last  output  1  final beat of the current command; qualified by dma_dvld.
- dma_rdata  output  32  aligned memory word; not shifted.
- dma_rbe  output  4  byte enables for dma_rdata.
- dma_dack  input  1  beat accept; transfer = dma_dvld & dma_dack.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_addr  output  32  word-aligned byte address; bits [1:0] = 0.
- mem_rd_data  input  32  read data, valid exactly one cycle after mem_rd_en.

## Operation
- States: IDLE, ACK, ISSUE, DRAIN.
- IDLE: all beats of the previous command have been accepted. If dma_r_req = 1, capture addr and len, then go to ACK.
- ACK: dma_r_ack = 1 for this cycle only, then go to ISSUE.
- ISSUE: assert mem_rd_en while credit > 0. Credit = FIFO_DEPTH − occupancy − in-flight reads.
  - mem_rd_addr starts at {addr[31:2],2'b00] and increments by 4, wrapping modulo 2^32.
  - After the last word is issued, go to DRAIN.
- DRAIN: wait until the FIFO is empty and no read is in flight, then go to IDLE.
- Word count: W = ((addr[1:0] + len) >> 2) + 1, computed in 17 bits. The maximum is len=16'hFFFF with addr[1:0]=3, giving W = 16385.
- Byte enables, with s = addr[1:0] and e = (addr[1:0] + len)[1:0]:
  - First word: bytes s..3.
  - Last word: bytes 0..e.
  - Single word (W = 1): bytes s..e.
  - Middle words: 4'hF.
- dma_rd_last is set on word W only and is stored in the FIFO alongside the data.
- A new command is never acked while any beat of the current command is outstanding. If dma_r_req is still high on return to IDLE, it is accepted as a new command.
- There is no abort. Only rstn terminates a transfer in progress.

## Timing
- Reset values:
  - dma_r_ack = 0, dma_dvld = 0, dma_rd_last = 0, dma_rdata = 0, dma_rbe = 0.
  - mem_rd_en = 0, mem_rd_addr = 0.
  - State = IDLE; FIFO and credit counters cleared.
- Command handshake, with dma_r_req first sampled high in IDLE at cycle N:
  - dma_r_ack is high in N+1.
  - First mem_rd_en is in N+2.
  - First dma_dvld is in N+4, driven from a registered FIFO output.
- With dma_dack held at 1, beats are back-to-back at 1 per cycle. The last beat of W words appears at N+3+W.
- Backpressure: when dma_dack = 0, dma_dvld, dma_rdata, dma_rbe and dma_rd_last are held stable. Issue stalls when credit reaches 0, so the FIFO never overflows.
- FIFO push and pop in the same cycle: occupancy is unchanged.
- Minimum IDLE-to-IDLE time for the next command: one cycle after the last beat is accepted.
- Asserting rstn mid-transfer discards all state immediately; no further beats or acks are produced.

## Configuration
- CDMA_RD_RESP_BE_EN defined: dma_rbe follows the first/last/single byte-enable rules above.
- CDMA_RD_RESP_BE_EN undefined: dma_rbe = 4'hF on every valid beat (4'h0 at reset). Word count and addressing are unchanged.

## Test plan
- Aligned command, addr=32'h100, len=23, dack=1:
  - ack at N+1.
  - 6 beats from N+4 to N+9, at mem addresses 0x100 to 0x114.
  - All rbe = 4'hF; rd_last on beat 6 only.
- Unaligned command, addr=32'h203, len=5:
  - W = 3, at mem addresses 0x200, 0x204, 0x208.
  - rbe = 4'h8, then 4'hF, then 4'h1.
- Single word, addr=32'h301, len=1:
  - 1 beat with rbe = 4'h6 and rd_last = 1.
- Backpressure, addr=0, len=63:
  - dack toggles 1,0,0,1 repeating.
  - All 16 words are delivered in order with no loss or duplication.
  - Outputs stay stable while dack = 0.
  - Never more than FIFO_DEPTH words are issued ahead of acceptance.
- Address wrap, addr=32'hFFFF_FFFC, len=7:
  - mem addresses 0xFFFF_FFFC, then 0x0000_0000.
  - 2 beats, rd_last on the second.
- Reset mid-transfer:
  - rstn low during beat 3 of a 6-beat command drives all outputs to 0.
  - After release with req high, a fresh ack arrives 1 cycle later.
